rf_write_sched: RTL and testbench

Write-port scheduler and load scoreboard for the 32x32 register file. It shares the file's single write port between the single-cycle ALU writeback path and the variable-latency load/store unit (LSU) return path. LSU returns wait in a small queue. A per-register busy bitmap tracks outstanding loads and drives decode RAW/WAW hazard stalls. It sits between execute/LSU writeback and the register file write inputs (RegWrite, DestR, WD3).

---
 rtl/rf_write_sched.sv | 93 +++++++++
 tb/tb_rf_write_sched.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/rf_write_sched.sv
// rf_write_sched: shares the register file write port between ALU writeback and a
// small load-return queue, and keeps a per-register busy bitmap for decode hazards.
module rf_write_sched #(
  parameter int LQ_DEPTH   = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      alu_valid,
  input  logic [4:0]                alu_rd,
  input  logic [31:0]               alu_data,
  output logic                      alu_ready,
  input  logic                      lsu_valid,
  input  logic [4:0]                lsu_rd,
  input  logic [31:0]               lsu_data,
  output logic                      lsu_ready,
  input  logic                      iss_valid,
  input  logic [4:0]                iss_rd,
  output logic                      iss_ready,
  input  logic [4:0]                q_rs1,
  input  logic [4:0]                q_rs2,
  input  logic [4:0]                q_rd,
  output logic                      hazard,
  output logic                      rf_we,
  output logic [4:0]                rf_waddr,
  output logic [31:0]               rf_wdata,
  output logic [$clog2(LQ_DEPTH):0] lq_count
);
  localparam int AW = $clog2(LQ_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH = CW'(LQ_DEPTH);
  localparam logic [SW-1:0] SMAX  = SW'(STARVE_MAX);

  logic [4:0]    rd_mem   [LQ_DEPTH];
  logic [31:0]   data_mem [LQ_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   busy_q, busy_d;
  logic          full, nonempty, head_pri, head_gnt, alu_gnt, push, iss_set;
  logic [4:0]    head_rd;

  assign full      = cnt_q == DEPTH;
  assign nonempty  = cnt_q != '0;
  assign head_rd   = rd_mem[rptr_q];
  assign head_pri  = nonempty && (full || starve_q == SMAX);
  assign head_gnt  = nonempty && (head_pri || !alu_valid);
  assign alu_gnt   = alu_valid && !head_pri;
  assign alu_ready = !head_pri;
  assign lsu_ready = !full;
  assign push      = lsu_valid && !full;
  assign iss_ready = !busy_q[iss_rd];
  assign iss_set   = iss_valid && iss_ready && iss_rd != '0;
  assign hazard    = busy_q[q_rs1] | busy_q[q_rs2] | busy_q[q_rd];
  assign rf_waddr  = head_gnt ? head_rd : alu_rd;
  assign rf_wdata  = head_gnt ? data_mem[rptr_q] : alu_data;
  // rst_n gates the ALU path too, which would otherwise write during reset
  assign rf_we     = rst_n && (head_gnt || alu_gnt) && rf_waddr != '0;
  assign lq_count  = cnt_q;
  assign cnt_d     = cnt_q + CW'(push) - CW'(head_gnt);
  assign starve_d  = (!nonempty || head_gnt) ? '0 : (starve_q == SMAX ? SMAX : starve_q + SW'(1));

  always_comb begin
    busy_d = busy_q;
    if (head_gnt) busy_d[head_rd] = 1'b0;
    if (iss_set) busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      busy_q   <= '0;
    end else begin
      wptr_q   <= wptr_q + AW'(push);
      rptr_q   <= rptr_q + AW'(head_gnt);
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wptr_q]   <= lsu_rd;
      data_mem[wptr_q] <= lsu_data;
    end
  end
endmodule

// File: tb/tb_rf_write_sched.sv
// tb_rf_write_sched: random traffic against a queue-based reference model; expected
// register writes go to a scoreboard that a negedge monitor drains.
module tb_rf_write_sched;
  localparam int LQ = 2;
  localparam int SMAX = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic alu_valid, lsu_valid, iss_valid;
  logic [4:0] alu_rd, lsu_rd, iss_rd, q_rs1, q_rs2, q_rd, rf_waddr;
  logic [31:0] alu_data, lsu_data, rf_wdata;
  logic alu_ready, lsu_ready, iss_ready, hazard, rf_we;
  logic [1:0] lq_count;

  always #5 clk = ~clk;

  rf_write_sched #(.LQ_DEPTH(LQ), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd), .hazard(hazard),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .lq_count(lq_count)
  );

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} ent_t;

  ent_t       mq[$];
  ent_t       exp_q[$];
  logic [4:0] outst[$];
  bit         busy[32];
  int         starve, lost_max_seen;
  int         checks = 0, failures = 0;
  bit         chk_en = 0, head_win, alu_hold;
  bit         e_alu_ready, e_lsu_ready, e_iss_ready, e_hazard, e_we;
  int         e_cnt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected outputs for the current cycle from the model state and driven inputs.
  task automatic eval();
    bit full, hp;
    ent_t w;
    full = mq.size() == LQ;
    hp = mq.size() > 0 && (full || starve == SMAX);
    head_win = mq.size() > 0 && (hp || !alu_valid);
    e_alu_ready = !hp;
    e_lsu_ready = !full;
    e_iss_ready = !busy[iss_rd];
    e_hazard = busy[q_rs1] | busy[q_rs2] | busy[q_rd];
    e_cnt = mq.size();
    alu_hold = alu_valid && hp;
    if (head_win) w = mq[0];
    else w = {alu_rd, alu_data};
    e_we = (head_win || (alu_valid && !hp)) && w.rd != 0;
    if (e_we) exp_q.push_back(w);
  endtask

  // Model state change at a rising edge.
  task automatic commit();
    bit full, iss_acc;
    full = mq.size() == LQ;
    iss_acc = iss_valid && !busy[iss_rd];
    if (iss_acc) outst.push_back(iss_rd);
    if (head_win) begin
      busy[mq[0].rd] = 0;
      void'(mq.pop_front());
      starve = 0;
    end else starve = mq.size() > 0 ? (starve < SMAX ? starve + 1 : SMAX) : 0;
    if (starve > lost_max_seen) lost_max_seen = starve;
    if (iss_acc && iss_rd != 0) busy[iss_rd] = 1;
    if (lsu_valid && !full) begin
      mq.push_back({lsu_rd, lsu_data});
      void'(outst.pop_front());
    end
  endtask

  task automatic cycle(int pa, int pl, int pi);
    @(posedge clk);
    commit();
    #1;
    if (!alu_hold) begin
      alu_valid = $urandom_range(99) < pa;
      alu_rd = 5'($urandom);
      alu_data = $urandom;
    end
    lsu_valid = outst.size() > 0 && $urandom_range(99) < pl;
    lsu_rd = outst.size() > 0 ? outst[0] : 5'($urandom);
    lsu_data = $urandom;
    iss_valid = $urandom_range(99) < pi;
    iss_rd = 5'($urandom_range(0, 9));
    q_rs1 = 5'($urandom_range(0, 9));
    q_rs2 = 5'($urandom_range(0, 9));
    q_rd = 5'($urandom_range(0, 9));
    eval();
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    outst.delete();
    foreach (busy[i]) busy[i] = 0;
    starve = 0;
    {alu_valid, lsu_valid, iss_valid} = '0;
    {alu_rd, lsu_rd, iss_rd, q_rs1, q_rs2, q_rd} = '0;
    {alu_data, lsu_data} = '0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) begin
      q_rs1 = 5'(r);
      q_rd = 5'(31 - r);
      #1 chk("hazard_after_reset", hazard, 0);
    end
    chk("lq_count_after_reset", lq_count, 0);
    q_rs1 = '0;
    q_rd = '0;
    eval();
    chk_en = 1;
  endtask

  always @(negedge clk) begin
    ent_t e;
    if (chk_en) begin
      chk("alu_ready", alu_ready, e_alu_ready);
      chk("lsu_ready", lsu_ready, e_lsu_ready);
      chk("iss_ready", iss_ready, e_iss_ready);
      chk("hazard", hazard, e_hazard);
      chk("lq_count", lq_count, e_cnt);
      chk("rf_we", rf_we, e_we);
      if (rf_we) begin
        if (exp_q.size() == 0) chk("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rf_waddr", rf_waddr, e.rd);
          chk("rf_wdata", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    model_clear();
    lost_max_seen = 0;
    alu_valid = 1'b1;
    alu_rd = 5'd3;
    alu_data = 32'h1234_5678;
    repeat (3) @(negedge clk) chk("we_in_reset", rf_we, 0);
    alu_valid = 1'b0;
    release_reset();
    repeat (300) cycle(100, 25, 60);
    repeat (300) cycle(50, 80, 70);
    repeat (300) cycle(20, 50, 50);
    for (int n = 0; n < 200 && mq.size() < LQ; n++) cycle(100, 90, 80);
    #2;
    chk_en = 0;
    chk("lq_full_before_reset", lq_count, LQ);
    rst_n = 1'b0;
    alu_valid = 1'b1;
    alu_rd = 5'd9;
    #1;
    chk("we_mid_reset", rf_we, 0);
    chk("lq_count_mid_reset", lq_count, 0);
    for (int r = 1; r < 32; r++) begin
      q_rs1 = 5'(r);
      #1 chk("hazard_mid_reset", hazard, 0);
    end
    model_clear();
    @(negedge clk);
    release_reset();
    repeat (400) cycle(70, 70, 70);
    repeat (60) cycle(0, 100, 0);
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("starvation_reached", lost_max_seen, SMAX);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
